chacha_block_core: RTL and testbench

Iterative ChaCha20 block function that sits directly upstream of and around the quarter-round datapath. It builds the 16-word initial state from key, nonce and block counter. It drives four chacha_qr instances, one column or diagonal half-round per cycle, and adds the initial state to the result. It emits one 512-bit keystream block per request to the downstream XOR/top-level stage.

---
 rtl/cc20_pkg.sv | 33 +++
 rtl/chacha_qr.sv | 36 +++
 rtl/chacha_block_core.sv | 111 +++++++++++
 tb/tb_chacha_block_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cc20_pkg.sv
// Shared types and constants for the ChaCha block core: sigma words, state
// layout, FSM encoding and the quarter-round word selection tables.
package cc20_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam int DEFAULT_ROUNDS = 20;

  typedef logic [31:0] word_t;
  // Packed so that word i occupies bits [32i+31:32i] when flattened.
  typedef logic [15:0][31:0] state_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} cc_state_e;

  // [quarter-round][a,b,c,d] -> state word index
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_qr
  import cc20_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t ra,
  output word_t rb,
  output word_t rc,
  output word_t rd
);

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign ra = a2;
  assign rb = b2;
  assign rc = c2;
  assign rd = d2;

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal half-round per
// cycle through four quarter-round units, then feed-forward add of the input.
module chacha_block_core
  import cc20_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS
)(
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic         start,
  output logic         ready,
  output logic [511:0] keystream,
  output logic         ks_valid,
  input  logic         ks_ack
);

  localparam int CTR_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  cc_state_e         state, state_nxt;
  logic [CTR_W-1:0]  round_ctr;
  state_t            init_reg, work_reg;
  state_t            init_state, round_out;
  word_t             qin  [4][4];
  word_t             qout [4][4];

  always_comb begin
    init_state     = '0;
    init_state[0]  = SIGMA0;
    init_state[1]  = SIGMA1;
    init_state[2]  = SIGMA2;
    init_state[3]  = SIGMA3;
    for (int k = 0; k < 8; k++) init_state[4+k] = key[32*k +: 32];
    init_state[12] = counter;
    for (int n = 0; n < 3; n++) init_state[13+n] = nonce[32*n +: 32];
  end

  // Odd half-rounds work on diagonals, even ones on columns.
  always_comb begin
    for (int q = 0; q < 4; q++)
      for (int j = 0; j < 4; j++)
        qin[q][j] = round_ctr[0] ? work_reg[DIAG_IDX[q][j]] : work_reg[COL_IDX[q][j]];
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_qr u_qr (
      .a  (qin[g][0]),
      .b  (qin[g][1]),
      .c  (qin[g][2]),
      .d  (qin[g][3]),
      .ra (qout[g][0]),
      .rb (qout[g][1]),
      .rc (qout[g][2]),
      .rd (qout[g][3])
    );
  end

  always_comb begin
    round_out = work_reg;
    for (int q = 0; q < 4; q++)
      for (int j = 0; j < 4; j++)
        if (round_ctr[0]) round_out[DIAG_IDX[q][j]] = qout[q][j];
        else              round_out[COL_IDX[q][j]]  = qout[q][j];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ROUND;
      ROUND: if (round_ctr == CTR_W'(ROUNDS - 1)) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE:  if (ks_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_ctr <= '0;
      init_reg  <= '0;
      work_reg  <= '0;
      keystream <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          init_reg  <= init_state;
          work_reg  <= init_state;
          round_ctr <= '0;
        end
        ROUND: begin
          work_reg  <= round_out;
          round_ctr <= round_ctr + 1'b1;
        end
        FINAL: for (int i = 0; i < 16; i++)
          keystream[32*i +: 32] <= work_reg[i] + init_reg[i];
        default: ;
      endcase
    end
  end

  assign ready    = (state == IDLE);
  assign ks_valid = (state == DONE);

endmodule

// File: tb/tb_chacha_block_core.sv
// Randomized and RFC-vector bench for chacha_block_core with a word-array
// reference model of the ChaCha block function.
module tb_chacha_block_core;

  localparam int ROUNDS = 20;

  logic         clk = 1'b0;
  logic         reset, start, ks_ack;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         ready, ks_valid;
  logic [511:0] keystream;

  int checks   = 0;
  int failures = 0;

  chacha_block_core #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .nonce     (nonce),
    .counter   (counter),
    .start     (start),
    .ready     (ready),
    .keystream (keystream),
    .ks_valid  (ks_valid),
    .ks_ack    (ks_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int sh);
    return (v << sh) | (v >> (32 - sh));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] a, b, cc, d;
    logic [511:0] r;
    int qt [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                      '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int dr = 0; dr < ROUNDS/2; dr++)
      for (int q = 0; q < 8; q++) begin
        a = x[qt[q][0]]; b = x[qt[q][1]]; cc = x[qt[q][2]]; d = x[qt[q][3]];
        a = a + b;  d = rotl(d ^ a, 16);
        cc = cc + d; b = rotl(b ^ cc, 12);
        a = a + b;  d = rotl(d ^ a, 8);
        cc = cc + d; b = rotl(b ^ cc, 7);
        x[qt[q][0]] = a; x[qt[q][1]] = b; x[qt[q][2]] = cc; x[qt[q][3]] = d;
      end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    int w = 0;
    while (!ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!ready) check("ready_wait", 512'(ready), 512'(1));
    key = k; nonce = n; counter = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ks_valid && lat < 200);
    if (!ks_valid) check("valid_timeout", 512'(ks_valid), 512'(1));
  endtask

  task automatic ack_block();
    ks_ack = 1'b1;
    @(posedge clk); #1;
    ks_ack = 1'b0;
  endtask

  logic [255:0] v1_key, rk [4];
  logic [95:0]  v1_nonce, rn [4];
  logic [31:0]  rc [4];
  logic [511:0] held, exp_blk, blk [2];
  int           lat, nacc, nblk, acc_t [2];
  logic         accepted;

  initial begin
    reset = 1'b1; start = 1'b0; ks_ack = 1'b0;
    key = '0; nonce = '0; counter = '0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) v1_key[32*k + 8*j +: 8] = 8'(4*k + j);
    v1_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", 512'(ready), 512'(1));
    check("rst_valid", 512'(ks_valid), 512'(0));
    check("rst_keystream", keystream, 512'(0));

    // RFC 7539 block function vector; start edge to DONE is ROUNDS+1 edges.
    issue(v1_key, v1_nonce, 32'd1);
    check("v1_ready_busy", 512'(ready), 512'(0));
    wait_valid(lat);
    check("v1_latency", 512'(lat), 512'(ROUNDS + 1));
    check("v1_w0", 512'(keystream[31:0]),    512'(32'he4e7f110));
    check("v1_w1", 512'(keystream[63:32]),   512'(32'h15593bd1));
    check("v1_w2", 512'(keystream[95:64]),   512'(32'h1fdd0f50));
    check("v1_w3", 512'(keystream[127:96]),  512'(32'hc47120a3));
    check("v1_w15", 512'(keystream[511:480]), 512'(32'h4e3c50a2));
    check("v1_model", keystream, ref_block(v1_key, v1_nonce, 32'd1));

    // Back-pressure with stray start pulses
    held = keystream;
    for (int i = 0; i < 50; i++) begin
      start = (i % 7 == 3);
      @(posedge clk); #1;
      if (i % 10 == 9) begin
        check("bp_valid", 512'(ks_valid), 512'(1));
        check("bp_ready", 512'(ready), 512'(0));
        check("bp_stable", keystream, held);
      end
    end
    start = 1'b0;
    ack_block();
    check("ack_ready", 512'(ready), 512'(1));
    check("ack_valid", 512'(ks_valid), 512'(0));
    check("ack_keep", keystream, held);
    repeat (30) @(posedge clk);
    #1 check("no_second_block", 512'(ks_valid), 512'(0));

    // RFC 7539 A.1 #1, all zero
    issue('0, '0, 32'd0);
    wait_valid(lat);
    check("v2_w0", 512'(keystream[31:0]),  512'(32'hade0b876));
    check("v2_w1", 512'(keystream[63:32]), 512'(32'h903df1a0));
    ack_block();

    // Reset with round_ctr at 7
    issue(v1_key, v1_nonce, 32'd1);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mid_rst_ready", 512'(ready), 512'(1));
    check("mid_rst_valid", 512'(ks_valid), 512'(0));
    check("mid_rst_keystream", keystream, 512'(0));
    issue(v1_key, v1_nonce, 32'd1);
    wait_valid(lat);
    check("post_rst_latency", 512'(lat), 512'(ROUNDS + 1));
    check("post_rst_v1", keystream, ref_block(v1_key, v1_nonce, 32'd1));
    ack_block();

    // Counter at the top of its range, then back to zero
    issue('0, '0, 32'hffffffff);
    wait_valid(lat);
    check("ctr_max", keystream, ref_block('0, '0, 32'hffffffff));
    ack_block();
    issue('0, '0, 32'd0);
    wait_valid(lat);
    check("ctr_zero_w0", 512'(keystream[31:0]), 512'(32'hade0b876));
    check("ctr_zero_w1", 512'(keystream[63:32]), 512'(32'h903df1a0));
    ack_block();

    // Random blocks with random ack delay
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) rk[t][32*i +: 32] = $urandom;
      for (int i = 0; i < 3; i++) rn[t][32*i +: 32] = $urandom;
      rc[t] = $urandom;
      issue(rk[t], rn[t], rc[t]);
      wait_valid(lat);
      exp_blk = ref_block(rk[t], rn[t], rc[t]);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 check("rand_block", keystream, exp_blk);
      ack_block();
    end

    // Back-to-back with ks_ack tied high
    ks_ack = 1'b1; nacc = 0; nblk = 0;
    for (int cyc = 0; cyc < 120 && nblk < 2; cyc++) begin
      if (ready && nacc < 2) begin
        key = rk[nacc]; nonce = rn[nacc]; counter = rc[nacc] ^ 32'h5a5a0000;
        start = 1'b1;
      end else start = 1'b0;
      accepted = ready && start;
      @(posedge clk); #1;
      if (accepted) begin acc_t[nacc] = cyc; nacc++; end
      if (ks_valid) begin blk[nblk] = keystream; nblk++; end
    end
    start = 1'b0; ks_ack = 1'b0;
    check("b2b_count", 512'(nblk), 512'(2));
    if (nacc == 2) check("b2b_interval", 512'(acc_t[1] - acc_t[0]), 512'(ROUNDS + 3));
    else check("b2b_accepts", 512'(nacc), 512'(2));
    for (int t = 0; t < 2; t++)
      if (t < nblk) check("b2b_block", blk[t], ref_block(rk[t], rn[t], rc[t] ^ 32'h5a5a0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
